// File: rtl/coeff_load_ctrl_if.sv
//------------------------------------------------------------------------------
// coeff_load_ctrl_if : host handshake and coefficient-RAM write bus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface coeff_load_ctrl_if;
  logic        iStart;
  logic        iCoeffValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady;
  logic        oCoeffiUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [3:0]  oAddrRam;
  logic [5:0]  oNumOfCoeff;
  logic [15:0] oWrDtRam;
  logic        oBusy;
  logic        oDone;

  modport slave (
    input  iStart, iCoeffValid, iCoeffData,
    output oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam,
           oAddrRam, oNumOfCoeff, oWrDtRam, oBusy, oDone
  );

  modport master (
    output iStart, iCoeffValid, iCoeffData,
    input  oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam,
           oAddrRam, oNumOfCoeff, oWrDtRam, oBusy, oDone
  );
endinterface

`default_nettype wire

// File: rtl/coeff_load_ctrl.sv
//------------------------------------------------------------------------------
// coeff_load_ctrl : loads FIR coefficients from a host into a 4x10 RAM,
//                   zero-padding unused slots. Option: COEFF_SYMMETRIC_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module coeff_load_ctrl #(
  parameter int NUM_TAPS  = 33,
  parameter int NUM_SLOTS = 40
) (
  input  logic              iClk_12M,
  input  logic              iRsn,
  coeff_load_ctrl_if.slave  bus
);

`ifdef COEFF_SYMMETRIC_EN
  localparam int HOST_WORDS = (NUM_TAPS + 1) / 2;
  localparam int HW         = (HOST_WORDS > 1) ? $clog2(HOST_WORDS) : 1;
`else
  localparam int HOST_WORDS = NUM_TAPS;
`endif

  localparam logic [5:0] c_taps  = 6'(NUM_TAPS);
  localparam logic [5:0] c_slots = 6'(NUM_SLOTS);
  localparam logic [5:0] c_host  = 6'(HOST_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_idx;
  logic        w_ready;
  logic        w_issue;
  logic [15:0] w_data;
  logic [5:0]  w_mod;
  logic [3:0]  w_addr;

  logic        r_csn;
  logic        r_wrn;
  logic [3:0]  r_addr;
  logic [5:0]  r_num;
  logic [15:0] r_wdata;

`ifdef COEFF_SYMMETRIC_EN
  logic [15:0] r_half [HOST_WORDS];
  logic [5:0]  w_sel;

  assign w_sel = c_taps - 6'd1 - r_idx;

  always_ff @(posedge iClk_12M) begin
    if (w_ready && bus.iCoeffValid)
      r_half[r_idx[HW-1:0]] <= bus.iCoeffData;
  end
`endif

  assign w_mod  = r_idx % 6'd10;
  assign w_addr = w_mod[3:0] + 4'd1;

  // r_idx is the next slot to be written; a slot is issued on the edge that
  // accepts/generates it, and its registered write appears one cycle later.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_issue = 1'b0;
    w_data  = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (bus.iStart)
          w_next = S_LOAD;
      end
      S_LOAD: begin
        if (r_idx < c_host) begin
          w_ready = 1'b1;
          w_issue = bus.iCoeffValid;
          w_data  = bus.iCoeffData;
        end
`ifdef COEFF_SYMMETRIC_EN
        else if (r_idx < c_taps) begin
          w_issue = 1'b1;
          w_data  = r_half[w_sel[HW-1:0]];
        end
`endif
        if (w_issue && (r_idx == c_taps - 6'd1) && (c_taps < c_slots))
          w_next = S_PAD;
        else if (r_idx == c_slots)
          w_next = S_DONE;
      end
      S_PAD: begin
        // The cycle after the last pad issue carries the final write.
        if (r_idx < c_slots)
          w_issue = 1'b1;
        else
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= S_IDLE;
      r_idx   <= 6'd0;
      r_csn   <= 1'b1;
      r_wrn   <= 1'b1;
      r_addr  <= 4'd0;
      r_num   <= 6'd0;
      r_wdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE)
        r_idx <= 6'd0;
      else if (w_issue)
        r_idx <= r_idx + 6'd1;
      r_csn <= ~w_issue;
      r_wrn <= ~w_issue;
      if (w_issue) begin
        r_num   <= r_idx;
        r_addr  <= w_addr;
        r_wdata <= w_data;
      end
    end
  end

  assign bus.oCoeffReady       = w_ready;
  assign bus.oCoeffiUpdateFlag = (r_state == S_LOAD) || (r_state == S_PAD);
  assign bus.oCsnRam           = r_csn;
  assign bus.oWrnRam           = r_wrn;
  assign bus.oAddrRam          = r_addr;
  assign bus.oNumOfCoeff       = r_num;
  assign bus.oWrDtRam          = r_wdata;
  assign bus.oBusy             = (r_state != S_IDLE);
  assign bus.oDone             = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_coeff_load_ctrl.sv
//------------------------------------------------------------------------------
// tb_coeff_load_ctrl : directed self-checking bench for coeff_load_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_coeff_load_ctrl;

`ifdef COEFF_SYMMETRIC_EN
  localparam int HOST = 17;
`else
  localparam int HOST = 33;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   nwr;
  int   ndone;
  logic [15:0] exp_slot [64];
  logic [15:0] got_data [40];
  logic [15:0] half_tbl [17] = '{16'h0003, 16'h0000, 16'hFFFA, 16'hFFF5,
                                 16'h0000, 16'h0012, 16'h0021, 16'h0000,
                                 16'hFFC8, 16'hFF9E, 16'h0000, 16'h0094,
                                 16'h0110, 16'h0000, 16'hFDE0, 16'h00CE,
                                 16'h01F4};

  coeff_load_ctrl_if bus ();

  coeff_load_ctrl #(.NUM_TAPS(33), .NUM_SLOTS(40)) dut (
    .iClk_12M (clk),
    .iRsn     (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_update(input bit stall, input int restart_at);
    int word, cyc, first_wr, last_wr;
    bit finished, prev_wr;
    word = 0; cyc = 0; first_wr = -1; last_wr = -1;
    finished = 0; prev_wr = 0; nwr = 0; ndone = 0;
    @(posedge clk); #1;
    bus.iStart = 1'b1; bus.iCoeffValid = 1'b1; bus.iCoeffData = exp_slot[0];
    checks++;
    if (bus.oCoeffReady !== 1'b0) begin
      errors++; $display("FAIL idle_ready got %b exp 0", bus.oCoeffReady);
    end
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    while (!finished && cyc < 300) begin
      bus.iCoeffValid = (word < HOST) && (!stall || (cyc % 2 == 0));
      bus.iCoeffData  = (word < HOST) ? exp_slot[word] : 16'hDEAD;
      bus.iStart      = (restart_at >= 0) && (word == restart_at);
      if (bus.oCsnRam === 1'b0) begin
        checks++;
        if ({bus.oWrnRam, bus.oNumOfCoeff, bus.oAddrRam, bus.oWrDtRam} !==
            {1'b0, 6'(nwr), 4'(nwr % 10 + 1), exp_slot[nwr]}) begin
          errors++;
          $display("FAIL write_%0d got wrn=%b num=%0d addr=%0d data=%h exp wrn=0 num=%0d addr=%0d data=%h",
                   nwr, bus.oWrnRam, bus.oNumOfCoeff, bus.oAddrRam, bus.oWrDtRam,
                   nwr, nwr % 10 + 1, exp_slot[nwr]);
        end
        if (nwr < 40) got_data[nwr] = bus.oWrDtRam;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        nwr++;
      end else begin
        checks++;
        if (bus.oWrnRam !== 1'b1) begin
          errors++; $display("FAIL idle_wrn got %b exp 1", bus.oWrnRam);
        end
      end
      if (bus.oDone === 1'b1) begin
        ndone++;
        checks++;
        if (!(prev_wr && nwr == 40)) begin
          errors++; $display("FAIL done_timing got writes=%0d prev_wr=%b exp 40/1", nwr, prev_wr);
        end
        checks++;
        if (bus.oCoeffiUpdateFlag !== 1'b0) begin
          errors++; $display("FAIL flag_in_done got %b exp 0", bus.oCoeffiUpdateFlag);
        end
        finished = 1;
      end else begin
        checks++;
        if (bus.oCoeffiUpdateFlag !== 1'b1) begin
          errors++; $display("FAIL flag_active got %b exp 1 (cycle %0d)", bus.oCoeffiUpdateFlag, cyc);
        end
      end
      prev_wr = (bus.oCsnRam === 1'b0);
      if (bus.iCoeffValid && bus.oCoeffReady === 1'b1) word++;
      cyc++;
      @(posedge clk); #1;
    end
    bus.iStart = 1'b0; bus.iCoeffValid = 1'b0;
    checks++;
    if (!finished) begin
      errors++; $display("FAIL done_timeout got no oDone exp oDone within 300 cycles");
    end
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oCsnRam, bus.oCoeffiUpdateFlag} !== 4'b0010) begin
      errors++; $display("FAIL after_done got busy/done/csn/flag=%b exp 0010",
                         {bus.oBusy, bus.oDone, bus.oCsnRam, bus.oCoeffiUpdateFlag});
    end
    checks++;
    if (nwr != 40) begin
      errors++; $display("FAIL write_count got %0d exp 40", nwr);
    end
    checks++;
    if (!stall && (last_wr - first_wr != 39)) begin
      errors++; $display("FAIL write_span got %0d exp 39", last_wr - first_wr);
    end else if (stall && (last_wr - first_wr <= 39)) begin
      errors++; $display("FAIL stall_gaps got span %0d exp >39", last_wr - first_wr);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oNumOfCoeff, bus.oWrDtRam} !== {2'b11, 26'd0}) begin
      errors++; $display("FAIL reset_ram got csn=%b wrn=%b addr=%0d num=%0d data=%h exp 1 1 0 0 0000",
                         bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oNumOfCoeff, bus.oWrDtRam);
    end
    checks++;
    if ({bus.oCoeffReady, bus.oCoeffiUpdateFlag, bus.oBusy, bus.oDone} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got ready/flag/busy/done=%b exp 0000",
                         {bus.oCoeffReady, bus.oCoeffiUpdateFlag, bus.oBusy, bus.oDone});
    end
  endtask

  task automatic test_full_stream();
    run_update(1'b0, -1);
  endtask

  task automatic test_slot_values();
    checks++;
    if (got_data[17] !== 16'h00CE) begin
      errors++; $display("FAIL slot17 got %h exp 00ce", got_data[17]);
    end
    checks++;
    if (got_data[32] !== 16'h0003) begin
      errors++; $display("FAIL slot32 got %h exp 0003", got_data[32]);
    end
    for (int i = 33; i < 40; i++) begin
      checks++;
      if (got_data[i] !== 16'h0000) begin
        errors++; $display("FAIL pad_slot%0d got %h exp 0000", i, got_data[i]);
      end
    end
  endtask

  task automatic test_stall();
    run_update(1'b1, -1);
  endtask

  task automatic test_restart_ignored();
    run_update(1'b0, 12);
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL restart_done_count got %0d exp 1", ndone);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.oBusy, bus.oCsnRam} !== 2'b01) begin
        errors++; $display("FAIL restart_idle got busy/csn=%b exp 01", {bus.oBusy, bus.oCsnRam});
      end
    end
  endtask

  task automatic test_reset_mid();
    int word, cyc;
    word = 0; cyc = 0;
    @(posedge clk); #1; bus.iStart = 1'b1;
    @(posedge clk); #1; bus.iStart = 1'b0;
    while (word < 20 && cyc < 100) begin
      bus.iCoeffValid = 1'b1;
      bus.iCoeffData  = exp_slot[word];
      if (bus.oCoeffReady === 1'b1) word++;
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.oCsnRam, bus.oNumOfCoeff} !== {1'b0, 6'd19}) begin
      errors++; $display("FAIL pre_reset_write got csn=%b num=%0d exp 0 19", bus.oCsnRam, bus.oNumOfCoeff);
    end
    rst_n = 1'b0;
    bus.iCoeffValid = 1'b0;
    #1;
    test_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.oBusy, bus.oCsnRam} !== 2'b01) begin
        errors++; $display("FAIL post_reset_idle got busy/csn=%b exp 01", {bus.oBusy, bus.oCsnRam});
      end
    end
    run_update(1'b0, -1);
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 64; i++) exp_slot[i] = 16'h0000;
    for (int i = 0; i < 33; i++) exp_slot[i] = (i <= 16) ? half_tbl[i] : half_tbl[32 - i];
    for (int i = 0; i < 40; i++) got_data[i] = 16'hXXXX;
    rst_n = 1'b0;
    bus.iStart = 1'b0; bus.iCoeffValid = 1'b0; bus.iCoeffData = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_full_stream();
    test_slot_values();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
